// File: rtl/tb_check_pkg.sv
// tb_check_pkg: shared state type, settle-timer width and the masked compare used by the response checker.
package tb_check_pkg;
   localparam int SETTLE_W = 4;
   localparam int MAX_W    = 64;
   typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, DONE} chk_state_t;
   // Case-inequality so an X/Z on any checked bit reads as a failure in simulation
   function automatic logic masked_mismatch(input logic [MAX_W-1:0] got, input logic [MAX_W-1:0] exp,
                                            input logic [MAX_W-1:0] mask);
      return ((got ^ exp) & mask) !== '0;
   endfunction
endpackage

// File: rtl/tb_settle_timer.sv
// tb_settle_timer: loadable down-counter that stops at zero and flags it.
module tb_settle_timer
   import tb_check_pkg::*;
#(
   parameter int W = SETTLE_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_zero
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge i_clk)
      if (i_rst) r_cnt <= '0;
      else if (i_load) r_cnt <= i_value;
      else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   assign o_zero = r_cnt == '0;
endmodule

// File: rtl/tb_response_checker.sv
// tb_response_checker: accepts expected vectors, samples the DUT after a settle delay,
// compares under a care mask and keeps pass/fail statistics plus the first failure.
module tb_response_checker
   import tb_check_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 1,
   parameter int IDX_W         = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             vec_valid,
   output logic             vec_ready,
   input  logic [WIDTH-1:0] vec_expect,
   input  logic [WIDTH-1:0] vec_mask,
   input  logic             vec_last,
   input  logic [WIDTH-1:0] dut_q,
   output logic [IDX_W-1:0] vec_count,
   output logic [IDX_W-1:0] err_count,
   output logic [IDX_W-1:0] first_err_idx,
   output logic [WIDTH-1:0] first_err_got,
   output logic [WIDTH-1:0] first_err_exp,
   output logic             done,
   output logic             pass
);
   localparam logic [SETTLE_W-1:0] LOAD_V = SETTLE_W'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);

   chk_state_t       r_state, w_next;
   logic             w_accept, w_zero, w_mis;
   logic             r_ready, r_done, r_last;
   logic [WIDTH-1:0] r_exp, r_mask, r_got, r_fexp;
   logic [IDX_W-1:0] r_vc, r_ec, r_fidx;

   assign w_accept = (r_state == IDLE) && vec_valid;
   assign w_mis    = masked_mismatch(MAX_W'(dut_q), MAX_W'(r_exp), MAX_W'(r_mask));

   tb_settle_timer #(.W(SETTLE_W)) u_timer (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_load (w_accept),
      .i_value(LOAD_V),
      .o_zero (w_zero)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (vec_valid) w_next = (SETTLE_CYCLES == 0) ? COMPARE : SETTLE;
         SETTLE:  if (w_zero) w_next = COMPARE;
         COMPARE: w_next = r_last ? DONE : IDLE;
         default: w_next = DONE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_exp   <= '0;
         r_mask  <= '0;
         r_last  <= 1'b0;
         r_vc    <= '0;
         r_ec    <= '0;
         r_fidx  <= '0;
         r_got   <= '0;
         r_fexp  <= '0;
      end else begin
         r_state <= w_next;
         r_ready <= w_next == IDLE;
         r_done  <= w_next == DONE;
         if (w_accept) begin
            r_exp  <= vec_expect;
            r_mask <= vec_mask;
            r_last <= vec_last;
         end
         if (r_state == COMPARE) begin
            r_vc <= r_vc + 1'b1;
            if (w_mis) begin
               if (r_ec != '1) r_ec <= r_ec + 1'b1;
               if (r_ec == '0) begin
                  r_fidx <= r_vc;
                  r_got  <= dut_q;
                  r_fexp <= r_exp;
               end
            end
         end
      end
   end

   assign vec_ready     = r_ready;
   assign done          = r_done;
   assign vec_count     = r_vc;
   assign err_count     = r_ec;
   assign first_err_idx = r_fidx;
   assign first_err_got = r_got;
   assign first_err_exp = r_fexp;
   assign pass          = r_done && (r_ec == '0);
endmodule

// File: tb/tb_tb_response_checker.sv
// tb_tb_response_checker: directed, table-driven checks of the response checker in three
// configurations (default, SETTLE_CYCLES=3, IDX_W=2).
module tb_tb_response_checker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        a_valid = 1'b0, a_last = 1'b0;
   logic [3:0]  a_exp = '0, a_mask = 4'hF, a_q = '0;
   logic        a_ready, a_done, a_pass;
   logic [15:0] a_vc, a_ec, a_fi;
   logic [3:0]  a_fg, a_fe;
   logic        c_ready, c_done, c_pass;
   logic [1:0]  c_vc, c_ec, c_fi;
   logic [3:0]  c_fg, c_fe;
   logic        b_valid = 1'b0, b_last = 1'b0;
   logic [3:0]  b_exp = '0, b_mask = 4'hF, b_q = '0;
   logic        b_ready, b_done, b_pass;
   logic [15:0] b_vc, b_ec, b_fi;
   logic [3:0]  b_fg, b_fe;

   tb_response_checker u_a (
      .CLK(clk), .RST(rst), .vec_valid(a_valid), .vec_ready(a_ready), .vec_expect(a_exp),
      .vec_mask(a_mask), .vec_last(a_last), .dut_q(a_q), .vec_count(a_vc), .err_count(a_ec),
      .first_err_idx(a_fi), .first_err_got(a_fg), .first_err_exp(a_fe), .done(a_done), .pass(a_pass)
   );
   tb_response_checker #(.IDX_W(2)) u_c (
      .CLK(clk), .RST(rst), .vec_valid(a_valid), .vec_ready(c_ready), .vec_expect(a_exp),
      .vec_mask(a_mask), .vec_last(a_last), .dut_q(a_q), .vec_count(c_vc), .err_count(c_ec),
      .first_err_idx(c_fi), .first_err_got(c_fg), .first_err_exp(c_fe), .done(c_done), .pass(c_pass)
   );
   tb_response_checker #(.SETTLE_CYCLES(3)) u_b (
      .CLK(clk), .RST(rst), .vec_valid(b_valid), .vec_ready(b_ready), .vec_expect(b_exp),
      .vec_mask(b_mask), .vec_last(b_last), .dut_q(b_q), .vec_count(b_vc), .err_count(b_ec),
      .first_err_idx(b_fi), .first_err_got(b_fg), .first_err_exp(b_fe), .done(b_done), .pass(b_pass)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   task automatic rst_dut();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
   endtask

   // One vector through the SETTLE_CYCLES=1 checkers; returns at the negedge after its compare
   task automatic send_a(input logic [3:0] e, input logic [3:0] m, input logic [3:0] q, input logic l);
      int n;
      n = 0;
      while (!a_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!a_ready) chk("ready_timeout", 32'(a_ready), 1);
      a_exp = e; a_mask = m; a_q = q; a_last = l; a_valid = 1'b1;
      @(posedge clk);
      #1 a_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic [3:0] e, m, q;
      logic       l;
      int         vc, ec;
      logic       dn, ps;
   } vec_t;
   vec_t tbl[8];

   logic [3:0]  m162;
   logic [14:0] pat, want_pat;

   initial begin
      tbl[0] = '{4'h0, 4'hF, 4'h0, 1'b0, 1, 0, 1'b0, 1'b0};
      tbl[1] = '{4'h1, 4'hF, 4'h1, 1'b0, 2, 0, 1'b0, 1'b0};
      tbl[2] = '{4'h2, 4'hF, 4'h2, 1'b0, 3, 0, 1'b0, 1'b0};
      tbl[3] = '{4'h3, 4'hF, 4'h7, 1'b0, 4, 1, 1'b0, 1'b0};
      tbl[4] = '{4'h0, 4'hE, 4'h1, 1'b0, 5, 1, 1'b0, 1'b0};
      tbl[5] = '{4'h0, 4'hF, 4'h1, 1'b0, 6, 2, 1'b0, 1'b0};
      tbl[6] = '{4'h5, 4'h0, 4'hA, 1'b0, 7, 2, 1'b0, 1'b0};
      tbl[7] = '{4'h9, 4'hF, 4'h8, 1'b1, 8, 3, 1'b1, 1'b0};

      rst_dut();
      chk("rst_ready", 32'(a_ready), 1);
      chk("rst_vc", 32'(a_vc), 0);
      chk("rst_ec", 32'(a_ec), 0);
      chk("rst_fi", 32'(a_fi), 0);
      chk("rst_fg_fe", {a_fg, a_fe}, 0);
      chk("rst_done_pass", {a_done, a_pass}, 0);
      chk("rst_b_ready", 32'(b_ready), 1);

      // Ten vectors against a good decade counter
      m162 = 4'h0;
      for (int i = 0; i < 10; i++) begin
         send_a(4'(i), 4'hF, m162, i == 9);
         m162 = (m162 == 4'h9) ? 4'h0 : m162 + 4'h1;
      end
      chk("t1_done", 32'(a_done), 1);
      chk("t1_pass", 32'(a_pass), 1);
      chk("t1_vc", 32'(a_vc), 10);
      chk("t1_ec", 32'(a_ec), 0);
      chk("t1_ready_in_done", 32'(a_ready), 0);
      a_valid = 1'b1;
      repeat (4) @(negedge clk);
      a_valid = 1'b0;
      chk("t1_done_ignores_valid", 32'(a_vc), 10);

      // Five mismatches: the IDX_W=2 instance saturates err_count and wraps vec_count
      rst_dut();
      for (int i = 0; i < 5; i++) send_a(4'h5, 4'hF, 4'hA + 4'(i), 1'b0);
      chk("t6_c_ec", 32'(c_ec), 3);
      chk("t6_c_vc", 32'(c_vc), 1);
      chk("t6_c_fi", 32'(c_fi), 0);
      chk("t6_c_fg", 32'(c_fg), 32'hA);
      chk("t6_a_ec", 32'(a_ec), 5);
      chk("t6_a_vc", 32'(a_vc), 5);

      rst_dut();
      for (int i = 0; i < 8; i++) begin
         send_a(tbl[i].e, tbl[i].m, tbl[i].q, tbl[i].l);
         chk($sformatf("tbl%0d_vc", i), 32'(a_vc), tbl[i].vc);
         chk($sformatf("tbl%0d_ec", i), 32'(a_ec), tbl[i].ec);
         chk($sformatf("tbl%0d_dp", i), {a_done, a_pass}, {tbl[i].dn, tbl[i].ps});
      end
      chk("t2_fi", 32'(a_fi), 3);
      chk("t2_fg", 32'(a_fg), 32'h7);
      chk("t2_fe", 32'(a_fe), 32'h3);

      // Reset while vector 5 is settling
      rst_dut();
      for (int i = 0; i < 5; i++) send_a(4'(i), 4'hF, (i == 2) ? 4'h6 : 4'(i), 1'b0);
      chk("t5_pre_ec", 32'(a_ec), 1);
      a_exp = 4'h5; a_q = 4'h5; a_valid = 1'b1;
      @(posedge clk);
      #1 a_valid = 1'b0;
      @(negedge clk);
      chk("t5_settling", 32'(a_ready), 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t5_ready", 32'(a_ready), 1);
      chk("t5_counts", {a_vc, a_ec}, 0);
      chk("t5_first", {a_fi, a_fg, a_fe}, 0);
      chk("t5_done_pass", {a_done, a_pass}, 0);
      send_a(4'h0, 4'hF, 4'h0, 1'b0);
      chk("t5_restart_vc", 32'(a_vc), 1);

      // SETTLE_CYCLES=3: throughput with valid held, then sample timing
      rst_dut();
      b_valid = 1'b1;
      for (int i = 0; i < 15; i++) begin
         pat[i] = b_ready;
         want_pat[i] = (i % 5) == 0;
         @(negedge clk);
      end
      b_valid = 1'b0;
      chk("t4_ready_pattern", 32'(pat), 32'(want_pat));
      chk("t4_vc", 32'(b_vc), 3);
      chk("t4_ec", 32'(b_ec), 0);
      b_q = 4'h3; b_exp = 4'h0; b_valid = 1'b1;
      @(posedge clk);
      #1 b_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 b_q = 4'h5;
      @(posedge clk);
      #1 b_q = 4'hC;
      @(posedge clk);
      #1 b_q = 4'h6;
      @(negedge clk);
      chk("t4_ec_after", 32'(b_ec), 1);
      chk("t4_sampled", 32'(b_fg), 32'hC);
      chk("t4_fe", 32'(b_fe), 0);
      chk("t4_fi", 32'(b_fi), 3);
      chk("t4_vc_after", 32'(b_vc), 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
